serial_shift_sequencer: RTL
===========================

# serial_shift_sequencer

Controller that serializes 4-bit words through the team's existing 4-bit left shift register (`shift_register`), MSB first. It accepts words over a valid/ready handshake and generates the register's `Load`, `Shift_Enable` and `Shift_In` controls. It holds each bit on the serial line for a programmable number of clock cycles and signals completion of each frame. It sits between a parallel producer (CPU bus or FIFO) and a bit-serial sink (LED driver, slow serial link).

## Interface
Parameters:
- `BIT_CYCLES`, default 1: clock cycles each bit is held on `Serial_Out`. Legal range 1..255.
- `FILL_BIT`, default 0: value driven on the register's `Shift_In` during shifts.

Ports:
- `CLK`, input, 1: single clock. All logic is rising-edge.
- `Reset`, input, 1: synchronous, active-high reset.
- `Data_In`, input, 4: word to serialize. Sampled on the accepting edge.
- `In_Valid`, input, 1: producer has a word.
- `In_Ready`, output, 1: sequencer accepts `Data_In` this cycle.
- `Pause`, input, 1: freezes an in-progress frame.
- `Serial_Out`, output, 1: current bit, equal to shift register bit 3. Forced 0 when `Serial_Valid`=0.
- `Serial_Valid`, output, 1: `Serial_Out` carries frame data.
- `Busy`, output, 1: a frame is in progress.
- `Done`, output, 1: one-cycle pulse on the last cycle of a frame's last bit.

## Operation
- **States:** IDLE and SHIFT. Internal counters are `bit_cnt` (2 bits, 0..3) and `tick_cnt` (8 bits, 0..`BIT_CYCLES`-1).
- **IDLE:**
  - `In_Ready`=1.
  - On `In_Valid`&&`In_Ready`, drive `Load`=1 so the register takes `Data_In` at that edge.
  - Clear `bit_cnt` and `tick_cnt`, then go to SHIFT.
- **SHIFT:**
  - `Serial_Valid`=1 and `Busy`=1.
  - `tick_cnt` increments each cycle in which `Pause`=0.
  - End-of-bit is the condition `tick_cnt`==`BIT_CYCLES`-1 && `Pause`=0.
- **End-of-bit with `bit_cnt`<3:**
  - Drive `Shift_Enable`=1 with `Shift_In`=`FILL_BIT`.
  - `bit_cnt`++ and `tick_cnt`=0.
- **End-of-bit with `bit_cnt`==3:**
  - `Done`=1 and `In_Ready`=1.
  - If `In_Valid`=1, drive `Load`=1, clear the counters and stay in SHIFT. This is a back-to-back frame with no idle gap.
  - Otherwise go to IDLE.
- **In_Ready elsewhere:** 0 in SHIFT except on the final end-of-bit cycle. A producer holding `In_Valid` simply waits.
- **Pause:**
  - In SHIFT, `Pause`=1 holds `tick_cnt`, `bit_cnt` and the register.
  - While paused, `Serial_Valid` stays 1, `Serial_Out` holds, and `Done` and `In_Ready` are 0.
  - In IDLE, `Pause` has no effect.
- **Load/shift priority:** `Load` and `Shift_Enable` are never asserted in the same cycle. `Load` takes priority by construction, because the final bit never shifts.

## Timing
- **Reset values:**
  - While `Reset`=1: state=IDLE, counters=0, `In_Ready`=0, `Serial_Valid`=0, `Serial_Out`=0, `Busy`=0, `Done`=0, `Load`=0, `Shift_Enable`=0.
  - `In_Ready` rises in the first cycle after `Reset` falls.
- **Reset mid-frame:** abandons the frame immediately.
  - No `Done` pulse.
  - Register contents are don't-care, because `Serial_Out` is masked by `Serial_Valid`.
- **Latency:** word accepted at edge k.
  - Bit 3 appears from cycle k+1.
  - Bit i (i=3..0) occupies cycles k+1+(3-i)·`BIT_CYCLES` through k+(4-i)·`BIT_CYCLES`.
  - `Done` is high in cycle k+4·`BIT_CYCLES`, excluding paused cycles.
- **Frame length:** exactly 4·`BIT_CYCLES` unpaused cycles.
- **Throughput:** back-to-back frames sustain 1 bit per `BIT_CYCLES` cycles with no gap cycle.
- **Simultaneous events:** `Pause`=1 on what would be the end-of-bit cycle suppresses that end-of-bit. The end-of-bit fires on the first following cycle with `Pause`=0.

## Structure
- Shared package:
  - State encoding `SEQ_IDLE`/`SEQ_SHIFT`.
  - Constant `SEQ_WORD_BITS`=4.
  - Constant `SEQ_TICK_W`=8.
- One sub-module: instantiate the existing `shift_register`.
  - Wiring: `Parallel_In`←`Data_In`, `Load`, `Shift_Enable`, `Shift_In`←`FILL_BIT`.
  - `Shift_Out` feeds `Serial_Out` through the `Serial_Valid` mask.
- The FSM and the counters live in the top module.

## Test plan
- **Single word:** `BIT_CYCLES`=1, `Data_In`=4'b1011 accepted at edge k. `Serial_Out`=1,0,1,1 in cycles k+1..k+4; `Done` only at k+4; `In_Ready`=1 again at k+5.
- **Stretched bits:** `BIT_CYCLES`=3, `Data_In`=4'b0110. Each bit is held 3 cycles (0,0,0,1,1,1,1,1,1,0,0,0); `Done` at k+12.
- **Back-to-back:** `BIT_CYCLES`=1, words 4'hA then 4'h5 with `In_Valid` held. Serial stream is 1010 0101 with no gap; `Done` at k+4 and k+8; `Serial_Valid` continuous.
- **Pause:** `BIT_CYCLES`=2, word 4'b1100, `Pause`=1 for 3 cycles starting mid-bit 2. Output holds; frame ends 3 cycles later than unpaused; no `Done` while paused.
- **Reset mid-frame:** `Reset` asserted 2 cycles into a frame. Next cycle all outputs are 0; no `Done`. A new word after reset serializes correctly.
- **Handshake stall:** `In_Valid` asserted mid-frame. `In_Ready` stays 0 until the final end-of-bit cycle; the word is accepted exactly once and not duplicated.

Source files
------------

// File: rtl/serial_shift_sequencer_pkg.sv
// Shared types and constants for the serial shift sequencer and its shift register.
package serial_shift_sequencer_pkg;

   typedef enum logic {
      SEQ_IDLE  = 1'b0,
      SEQ_SHIFT = 1'b1
   } seq_state_t;

   localparam int SEQ_WORD_BITS = 4;
   localparam int SEQ_TICK_W    = 8;

endpackage

// File: rtl/serial_shift_sequencer_shift_register.sv
// 4-bit left shift register: parallel load has priority, MSB is the serial output.
module shift_register
   import serial_shift_sequencer_pkg::*;
(
   input  logic                     CLK,
   input  logic                     Reset,
   input  logic [SEQ_WORD_BITS-1:0] Parallel_In,
   input  logic                     Load,
   input  logic                     Shift_Enable,
   input  logic                     Shift_In,
   output logic                     Shift_Out
);

   logic [SEQ_WORD_BITS-1:0] r_data;

   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_data <= '0;
      end else if (Load) begin
         r_data <= Parallel_In;
      end else if (Shift_Enable) begin
         r_data <= {r_data[SEQ_WORD_BITS-2:0], Shift_In};
      end
   end

   assign Shift_Out = r_data[SEQ_WORD_BITS-1];

endmodule

// File: rtl/serial_shift_sequencer.sv
// Serializes 4-bit words MSB first through shift_register, holding each bit
// BIT_CYCLES clocks, with valid/ready intake, pause and per-frame done pulse.
//
// state     | meaning
// SEQ_IDLE  | no frame; In_Ready high, a valid word is loaded and starts a frame
// SEQ_SHIFT | frame in progress; bit held for BIT_CYCLES unpaused cycles each
module serial_shift_sequencer
   import serial_shift_sequencer_pkg::*;
#(
   parameter int unsigned BIT_CYCLES = 1,
   parameter logic        FILL_BIT   = 1'b0
) (
   input  logic                     CLK,
   input  logic                     Reset,
   input  logic [SEQ_WORD_BITS-1:0] Data_In,
   input  logic                     In_Valid,
   output logic                     In_Ready,
   input  logic                     Pause,
   output logic                     Serial_Out,
   output logic                     Serial_Valid,
   output logic                     Busy,
   output logic                     Done
);

   localparam logic [SEQ_TICK_W-1:0] LP_TICK_LAST = SEQ_TICK_W'(BIT_CYCLES - 1);

   seq_state_t            r_state;
   seq_state_t            w_next_state;
   logic [1:0]            r_bit_cnt;
   logic [SEQ_TICK_W-1:0] r_tick_cnt;

   logic w_active;
   logic w_eob;
   logic w_last;
   logic w_in_ready;
   logic w_load;
   logic w_shift_en;
   logic w_done;
   logic w_shift_out;

   // Everything is gated by Reset so outputs are quiet during the reset cycle itself.
   assign w_active = !Reset && (r_state == SEQ_SHIFT);
   assign w_eob    = w_active && !Pause && (r_tick_cnt == LP_TICK_LAST);
   assign w_last   = w_eob && (r_bit_cnt == 2'd3);

   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_state <= SEQ_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         SEQ_IDLE:  if (w_load) w_next_state = SEQ_SHIFT;
         SEQ_SHIFT: if (w_last && !In_Valid) w_next_state = SEQ_IDLE;
         default:   w_next_state = SEQ_IDLE;
      endcase
   end

   always_comb begin
      w_in_ready = 1'b0;
      w_shift_en = 1'b0;
      w_done     = 1'b0;
      if (!Reset) begin
         case (r_state)
            SEQ_IDLE: w_in_ready = 1'b1;
            SEQ_SHIFT: begin
               w_in_ready = w_last;
               w_done     = w_last;
               w_shift_en = w_eob && !w_last;
            end
            default: ;
         endcase
      end
      w_load = w_in_ready && In_Valid;
   end

   always_ff @(posedge CLK) begin
      if (Reset || w_load || (w_last && !In_Valid)) begin
         r_bit_cnt  <= '0;
         r_tick_cnt <= '0;
      end else if (w_shift_en) begin
         r_bit_cnt  <= r_bit_cnt + 2'd1;
         r_tick_cnt <= '0;
      end else if (w_active && !Pause) begin
         r_tick_cnt <= r_tick_cnt + 1'b1;
      end
   end

   shift_register u_shift_register (
      .CLK          (CLK),
      .Reset        (Reset),
      .Parallel_In  (Data_In),
      .Load         (w_load),
      .Shift_Enable (w_shift_en),
      .Shift_In     (FILL_BIT),
      .Shift_Out    (w_shift_out)
   );

   assign In_Ready     = w_in_ready;
   assign Serial_Valid = w_active;
   assign Busy         = w_active;
   assign Serial_Out   = w_shift_out & w_active;
   assign Done         = w_done;

endmodule
